// File: rtl/eb_sink_checker_if.sv
// Req/ack stream bundle between a producer and the eb_sink_checker.
//   t_dat : stream data, driven by the producer
//   t_req : data valid, driven by the producer
//   t_ack : acknowledge, driven by the consumer
// A word moves on a rising clock edge where t_req and t_ack are both high.
interface eb_sink_checker_if #(
  parameter int W = 32
);
  logic [W-1:0] t_dat;
  logic         t_req;
  logic         t_ack;

  modport master (output t_dat, output t_req, input t_ack);
  modport slave  (input t_dat, input t_req, output t_ack);
endinterface

// File: rtl/eb_sink_checker.sv
// Stream sink that terminates a req/ack stream. It offers t_ack according to
// a rotating backpressure pattern, checks each accepted word against an
// arithmetic sequence SEED, SEED+STEP, ... and reports results.
//   clk, reset_n     : clock, asynchronous active-low reset
//   eb (slave)       : t_dat/t_req in, t_ack out
//   start            : one-cycle run start (ignored while running)
//   len, ack_pat,
//   stop_on_err      : run configuration, sampled on an honoured start
//   xfer_cnt/err_cnt : accepted / mismatching words this run
//   err_dat/exp/idx  : capture of the first mismatch
//   proto_err        : sticky producer protocol violation
//   stt              : 00 IDLE, 01 RUN, 10 DONE, 11 FAIL
//
// state | meaning
// IDLE  | out of reset, no run started yet, t_ack low
// RUN   | accepting words, pattern rotating, protocol checked
// DONE  | len words accepted, results held
// FAIL  | mismatch with stop_on_err set, results held
module eb_sink_checker #(
  parameter int             W    = 32,
  parameter int             CW   = 16,
  parameter logic [W-1:0]   SEED = '0,
  parameter logic [W-1:0]   STEP = W'(1),
  parameter int             PW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  eb_sink_checker_if.slave  eb,
  input  logic              start,
  input  logic [CW-1:0]     len,
  input  logic [PW-1:0]     ack_pat,
  input  logic              stop_on_err,
  output logic [CW-1:0]     xfer_cnt,
  output logic [CW-1:0]     err_cnt,
  output logic [W-1:0]      err_dat,
  output logic [W-1:0]      err_exp,
  output logic [CW-1:0]     err_idx,
  output logic              proto_err,
  output logic [1:0]        stt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_FAIL = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [W-1:0]  exp_q, exp_d;
  logic [CW-1:0] len_q, len_d;
  logic          stop_q, stop_d;
  logic [CW-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]  err_dat_q, err_dat_d;
  logic [W-1:0]  err_exp_q, err_exp_d;
  logic [CW-1:0] err_idx_q, err_idx_d;
  logic          proto_q, proto_d;
  logic          pend_q, pend_d;
  logic [W-1:0]  prev_dat_q, prev_dat_d;

  logic ack;
  logic xfer;
  logic mism;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    exp_d      = exp_q;
    len_d      = len_q;
    stop_d     = stop_q;
    xfer_cnt_d = xfer_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_dat_d  = err_dat_q;
    err_exp_d  = err_exp_q;
    err_idx_d  = err_idx_q;
    proto_d    = proto_q;
    pend_d     = 1'b0;
    prev_dat_d = eb.t_dat;

    // t_ack comes only from flops, so there is no path from t_req/t_dat.
    ack  = (state_q == ST_RUN) & pat_q[0];
    xfer = eb.t_req & ack;
    mism = (eb.t_dat != exp_q);

    case (state_q)
      ST_RUN: begin
        pat_d  = {pat_q[0], pat_q[PW-1:1]};
        // A request left waiting must be held with stable data.
        pend_d = eb.t_req & ~ack;
        if (pend_q && (!eb.t_req || (eb.t_dat != prev_dat_q))) begin
          proto_d = 1'b1;
        end
        if (xfer) begin
          exp_d      = exp_q + STEP;
          xfer_cnt_d = xfer_cnt_q + 1'b1;
          if (xfer_cnt_d == len_q) begin
            state_d = ST_DONE;
          end
          if (mism) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err_cnt_q == '0) begin
              err_dat_d = eb.t_dat;
              err_exp_d = exp_q;
              err_idx_d = xfer_cnt_q;
            end
            // Stop-on-error wins over a simultaneous final transfer.
            if (stop_q) begin
              state_d = ST_FAIL;
            end
          end
        end
      end
      default: begin
        if (start) begin
          exp_d      = SEED;
          xfer_cnt_d = '0;
          err_cnt_d  = '0;
          err_dat_d  = '0;
          err_exp_d  = '0;
          err_idx_d  = '0;
          proto_d    = 1'b0;
          len_d      = len;
          stop_d     = stop_on_err;
          // An all-zero pattern would never acknowledge; treat it as always-ack.
          pat_d      = (ack_pat == '0) ? '1 : ack_pat;
          state_d    = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      exp_q      <= SEED;
      len_q      <= '0;
      stop_q     <= 1'b0;
      xfer_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_dat_q  <= '0;
      err_exp_q  <= '0;
      err_idx_q  <= '0;
      proto_q    <= 1'b0;
      pend_q     <= 1'b0;
      prev_dat_q <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      exp_q      <= exp_d;
      len_q      <= len_d;
      stop_q     <= stop_d;
      xfer_cnt_q <= xfer_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_dat_q  <= err_dat_d;
      err_exp_q  <= err_exp_d;
      err_idx_q  <= err_idx_d;
      proto_q    <= proto_d;
      pend_q     <= pend_d;
      prev_dat_q <= prev_dat_d;
    end
  end

  assign eb.t_ack  = ack;
  assign xfer_cnt  = xfer_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_dat   = err_dat_q;
  assign err_exp   = err_exp_q;
  assign err_idx   = err_idx_q;
  assign proto_err = proto_q;
  assign stt       = state_q;

endmodule

// File: doc/eb_sink_checker.md
Name: eb_sink_checker

Overview:
- Elastic-stream responder that terminates a req/ack stream at the consumer end.
- Drives programmable backpressure on t_ack and checks every accepted word against an expected arithmetic sequence.
- Counts transfers and mismatches, captures the first mismatch, and flags producer protocol violations.
- Used in benches and on-chip self-test downstream of elastic buffer stages.

Parameters:
W, 32, data width
CW, 16, transfer/error counter and length width
SEED, 0, first expected data word (W bits)
STEP, 1, expected-sequence increment per accepted word (W bits, modulo 2^W)
PW, 8, backpressure pattern width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
t_dat  input  W  stream data from producer
t_req  input  1  producer request (data valid)
t_ack  output  1  acknowledge to producer
start  input  1  single-cycle run start
len  input  CW  number of transfers to accept per run; sampled on start
ack_pat  input  PW  backpressure pattern; bit=1 means ack offered; sampled on start
stop_on_err  input  1  enter FAIL on first mismatch; sampled on start
xfer_cnt  output  CW  accepted transfers this run
err_cnt  output  CW  mismatching transfers this run (saturating)
err_dat  output  W  t_dat of first mismatch
err_exp  output  W  expected value at first mismatch
err_idx  output  CW  xfer_cnt value at first mismatch
proto_err  output  1  sticky producer protocol violation
stt  output  2  state: IDLE=00, RUN=01, DONE=10, FAIL=11

Behaviour:
- Reset: state IDLE; every output 0; internal exp=SEED, pat=0, len_r=0, stop_r=0.
- Transfer: xfer = t_req & t_ack, evaluated at the rising clk edge. No combinational path from t_req or t_dat to t_ack.
- t_ack = (state==RUN) & pat[0]. Always 0 in IDLE, DONE and FAIL.
- pat rotates right by one every cycle in RUN, independent of xfer. It holds in all other states.
- start is honoured in IDLE, DONE and FAIL, and ignored in RUN. When honoured:
  - exp<=SEED; xfer_cnt, err_cnt, err_dat, err_exp, err_idx <= 0; proto_err <= 0.
  - len_r<=len; stop_r<=stop_on_err.
  - pat<=ack_pat, except ack_pat==0 loads all-ones (deadlock guard).
  - Next state: RUN, or DONE directly when len==0.
- On each xfer in RUN:
  - exp<=exp+STEP, wrapping modulo 2^W.
  - xfer_cnt++.
  - If t_dat!=exp: err_cnt++, saturating at 2^CW-1.
  - If it is the first mismatch (err_cnt==0 before the update): err_dat<=t_dat, err_exp<=exp, err_idx<=xfer_cnt (pre-increment).
- RUN exit:
  - Mismatch xfer with stop_r=1 -> FAIL.
  - Else xfer with xfer_cnt+1==len_r -> DONE.
  - FAIL has priority when both hold on the same transfer.
- First ack latency: ack is offered in the first RUN cycle if ack_pat[0]=1, i.e. the cycle after start.
- Protocol check, active in RUN only. A cycle with t_req=1 & t_ack=0 is pending. If the next cycle is still RUN and either t_req==0 or t_dat differs from the pending-cycle value, proto_err<=1 (sticky until start or reset). Register the previous t_req, t_dat and pending bit for this check.
- Counters and captures hold in DONE and FAIL. Producer activity outside RUN is ignored and raises no proto_err.
- reset_n low at any time, including mid-run, returns everything to reset values asynchronously. The first ack after reset is not possible until a start has been honoured.

Test Plan:
- Basic run: SEED=0, STEP=1, ack_pat=8'hFF, len=4, producer sends 0,1,2,3 with req held -> t_ack high from cycle after start, 4 transfers in 4 cycles, stt=10, xfer_cnt=4, err_cnt=0, proto_err=0.
- Backpressure: ack_pat=8'b0000_0101, len=8, producer always requesting -> t_ack high only on rotation cycles 0,2 of each 8-cycle window, DONE after 32 RUN cycles, no errors.
- Mismatch, continue: len=5, stop_on_err=0, producer sends 0,1,7,3,9 -> stt=10, err_cnt=2, err_dat=7, err_exp=2, err_idx=2.
- Mismatch, stop: same stimulus with stop_on_err=1 -> stt=11 after third transfer, xfer_cnt=3, t_ack=0 thereafter.
- Protocol violation: ack_pat=8'h01, producer raises req with data 0 then drops req the next cycle while unacked -> proto_err=1, persists until next start clears it.
- Edges:
  - len=0 -> DONE the cycle after start, no ack.
  - ack_pat=0 -> behaves as 8'hFF.
  - Reset asserted mid-run -> all outputs 0, stt=00.
  - SEED=32'hFFFF_FFFF, len=2 -> expects FFFF_FFFF then 0.
